// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - byte-enabled word RAM responder with wait states and error completion
module dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    output logic        err_o
);

    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                  state;
    logic [3:0]              cnt;
    logic                    req_we;
    logic [3:0]              req_sel;
    logic [ADDR_WIDTH-1:0]   req_idx;
    logic [31:0]             req_dat;
    logic                    req_err;

    logic [31:0]             ram [DEPTH];

    logic                    sel_ok;
    logic                    req_now;
    logic                    in_err;
    logic [ADDR_WIDTH-1:0]   in_idx;
    logic                    in_idle;
    logic                    acc_we;
    logic [3:0]              acc_sel;
    logic [ADDR_WIDTH-1:0]   acc_idx;
    logic [31:0]             acc_dat;
    logic                    acc_err;
    logic                    fire;
    logic                    wr_en;
    logic                    rd_en;
    logic                    unused_adr;

    always_comb begin
        sel_ok = 1'b0;
        case (sel_i)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: sel_ok = 1'b1;
            default:                   sel_ok = 1'b0;
        endcase
    end

    assign req_now    = cyc_i & stb_i;
    assign in_err     = !sel_ok || (adr_i[31:ADDR_WIDTH+2] != '0);
    assign in_idx     = adr_i[ADDR_WIDTH+1:2];
    assign in_idle    = (state == IDLE);
    assign unused_adr = ^adr_i[1:0];

    // With no wait states the RAM is accessed straight from the bus at the accept edge,
    // otherwise from the request latched at accept.
    assign acc_we  = in_idle ? we_i   : req_we;
    assign acc_sel = in_idle ? sel_i  : req_sel;
    assign acc_idx = in_idle ? in_idx : req_idx;
    assign acc_dat = in_idle ? dat_i  : req_dat;
    assign acc_err = in_idle ? in_err : req_err;

    assign fire  = (in_idle && req_now && (WAIT_CYCLES == 0)) ||
                   ((state == WAIT) && cyc_i && (cnt == 4'd0));
    assign wr_en = fire && reset_n && acc_we && !acc_err;
    assign rd_en = fire && !acc_we && !acc_err;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (acc_sel[0]) ram[acc_idx][7:0]   <= acc_dat[7:0];
            if (acc_sel[1]) ram[acc_idx][15:8]  <= acc_dat[15:8];
            if (acc_sel[2]) ram[acc_idx][23:16] <= acc_dat[23:16];
            if (acc_sel[3]) ram[acc_idx][31:24] <= acc_dat[31:24];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            req_we  <= 1'b0;
            req_sel <= 4'd0;
            req_idx <= '0;
            req_dat <= 32'd0;
            req_err <= 1'b0;
            dat_o   <= 32'd0;
            ack_o   <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_now) begin
                        req_we  <= we_i;
                        req_sel <= sel_i;
                        req_idx <= in_idx;
                        req_dat <= dat_i;
                        req_err <= in_err;
                        if (WAIT_CYCLES > 0) begin
                            state <= WAIT;
                            cnt   <= WAIT_LOAD;
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                WAIT: begin
                    if (!cyc_i) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
            if (fire) begin
                ack_o <= !acc_err;
                err_o <= acc_err;
            end
            if (rd_en) begin
                dat_o <= ram[acc_idx];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder at 1, 3 and 0 wait states
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n [3];
    logic        cyc   [3];
    logic        stb   [3];
    logic        we    [3];
    logic [3:0]  sel   [3];
    logic [31:0] adr   [3];
    logic [31:0] dat_w [3];
    logic [31:0] dat_r [3];
    logic        ack   [3];
    logic        err   [3];

    int          wc [3] = '{1, 3, 0};
    int          errors = 0;
    int          checks = 0;

    logic [31:0] mm      [3][1024];
    logic [31:0] last_rd [3];

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] wd;
        logic        eack;
        logic        eerr;
        logic [31:0] edat;
    } vec_t;

    vec_t tbl [14];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(
            .ADDR_WIDTH (10),
            .WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 3 : 0))
        ) u_dut (
            .clk    (clk),
            .reset_n(rst_n[g]),
            .cyc_i  (cyc[g]),
            .stb_i  (stb[g]),
            .we_i   (we[g]),
            .sel_i  (sel[g]),
            .adr_i  (adr[g]),
            .dat_i  (dat_w[g]),
            .dat_o  (dat_r[g]),
            .ack_o  (ack[g]),
            .err_o  (err[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // legal lanes: a single byte, an aligned halfword, or the whole word
    function automatic bit sel_legal(input logic [3:0] s);
        return ($countones(s) == 1) || (s == 4'b0011) || (s == 4'b1100) || (s == 4'b1111);
    endfunction

    task automatic do_xfer(input int d, input bit w, input logic [3:0] s, input logic [31:0] a,
                           input logic [31:0] wd, output bit ga, output bit ge,
                           output logic [31:0] rd, output int lat);
        @(negedge clk);
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; sel[d] = s; adr[d] = a; dat_w[d] = wd;
        ga = 1'b0; ge = 1'b0; rd = 32'd0; lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (ack[d] || err[d]) begin
                ga = ack[d]; ge = err[d]; rd = dat_r[d]; lat = i;
                break;
            end
        end
        cyc[d] = 1'b0; stb[d] = 1'b0;
    endtask

    task automatic run_chk(input int d, input bit w, input logic [3:0] s, input logic [31:0] a,
                           input logic [31:0] wd, input string tag);
        bit          ga, ge, e_err;
        logic [31:0] rd;
        int          lat;
        int          idx;
        e_err = !sel_legal(s) || (a[31:12] != 20'd0);
        idx   = int'(a[11:2]);
        do_xfer(d, w, s, a, wd, ga, ge, rd, lat);
        chk({tag, "_ack"}, 32'(ga), 32'(!e_err));
        chk({tag, "_err"}, 32'(ge), 32'(e_err));
        chk({tag, "_lat"}, 32'(lat), 32'(wc[d] + 1));
        if (!w && !e_err) last_rd[d] = mm[d][idx];
        chk({tag, "_dat"}, rd, last_rd[d]);
        if (w && !e_err)
            for (int k = 0; k < 4; k++)
                if (s[k]) mm[d][idx][8*k +: 8] = wd[8*k +: 8];
    endtask

    task automatic rand_phase(input int d, input int n);
        logic [31:0] a;
        for (int i = 0; i < 16; i++) run_chk(d, 1'b1, 4'hF, 32'(i * 4), $urandom, $sformatf("fill%0d_%0d", d, i));
        for (int i = 0; i < n; i++) begin
            a = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(12, 31));
            run_chk(d, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom,
                    $sformatf("rnd%0d_%0d", d, i));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit          ga, ge;
        logic [31:0] rd;
        int          lat;
        int          k;

        tbl[0]  = '{1'b1, 4'hF, 32'h40,   32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 4'hF, 32'h40,   32'h0,        1'b1, 1'b0, 32'hDEADBEEF};
        tbl[2]  = '{1'b1, 4'h4, 32'h42,   32'h00AA0000, 1'b1, 1'b0, 32'hDEADBEEF};
        tbl[3]  = '{1'b0, 4'hF, 32'h40,   32'h0,        1'b1, 1'b0, 32'hDEAABEEF};
        tbl[4]  = '{1'b1, 4'hC, 32'h80,   32'h12340000, 1'b1, 1'b0, 32'hDEAABEEF};
        tbl[5]  = '{1'b1, 4'h3, 32'h80,   32'h00005678, 1'b1, 1'b0, 32'hDEAABEEF};
        tbl[6]  = '{1'b0, 4'hF, 32'h80,   32'h0,        1'b1, 1'b0, 32'h12345678};
        tbl[7]  = '{1'b1, 4'h5, 32'h40,   32'hFFFFFFFF, 1'b0, 1'b1, 32'h12345678};
        tbl[8]  = '{1'b0, 4'hF, 32'h40,   32'h0,        1'b1, 1'b0, 32'hDEAABEEF};
        tbl[9]  = '{1'b0, 4'hF, 32'h1000, 32'h0,        1'b0, 1'b1, 32'hDEAABEEF};
        tbl[10] = '{1'b0, 4'h0, 32'h80,   32'h0,        1'b0, 1'b1, 32'hDEAABEEF};
        tbl[11] = '{1'b0, 4'h1, 32'h82,   32'h0,        1'b1, 1'b0, 32'h12345678};
        tbl[12] = '{1'b1, 4'h9, 32'h80,   32'hABABABAB, 1'b0, 1'b1, 32'h12345678};
        tbl[13] = '{1'b0, 4'hF, 32'h80,   32'h0,        1'b1, 1'b0, 32'h12345678};

        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 1'b0; cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
            sel[d] = 4'd0; adr[d] = 32'd0; dat_w[d] = 32'd0; last_rd[d] = 32'd0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_ack%0d", d), 32'(ack[d]), 32'd0);
            chk($sformatf("rst_err%0d", d), 32'(err[d]), 32'd0);
            chk($sformatf("rst_dat%0d", d), dat_r[d], 32'd0);
        end
        for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;

        // directed vectors, one wait state
        for (int i = 0; i < 14; i++) begin
            do_xfer(0, tbl[i].we, tbl[i].sel, tbl[i].adr, tbl[i].wd, ga, ge, rd, lat);
            chk($sformatf("tbl%0d_ack", i), 32'(ga), 32'(tbl[i].eack));
            chk($sformatf("tbl%0d_err", i), 32'(ge), 32'(tbl[i].eerr));
            chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'd2);
            chk($sformatf("tbl%0d_dat", i), rd, tbl[i].edat);
        end
        last_rd[0] = 32'h12345678;
        rand_phase(0, 40);

        // three wait states: abort in the second wait cycle
        run_chk(1, 1'b1, 4'hF, 32'h20, 32'h11111111, "s5_wr");
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 4'hF; adr[1] = 32'h20; dat_w[1] = 32'h22222222;
        @(negedge clk);
        chk("s5_abort_w1", 32'(ack[1] | err[1]), 32'd0);
        @(negedge clk);
        cyc[1] = 1'b0; stb[1] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("s5_abort_quiet%0d", i), 32'(ack[1] | err[1]), 32'd0);
        end
        run_chk(1, 1'b0, 4'hF, 32'h20, 32'h0, "s5_rd_after_abort");

        // reset during a wait cycle
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 4'hF; adr[1] = 32'h20; dat_w[1] = 32'h33333333;
        @(negedge clk);
        rst_n[1] = 1'b0;
        #1;
        chk("s5_rst_ack", 32'(ack[1]), 32'd0);
        chk("s5_rst_err", 32'(err[1]), 32'd0);
        chk("s5_rst_dat", dat_r[1], 32'd0);
        cyc[1] = 1'b0; stb[1] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n[1] = 1'b1;
        last_rd[1] = 32'd0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("s5_rst_quiet%0d", i), 32'(ack[1] | err[1]), 32'd0);
        end
        run_chk(1, 1'b0, 4'hF, 32'h20, 32'h0, "s5_rd_after_rst");

        // zero wait states: random traffic, then stb held across three reads
        rand_phase(2, 40);
        @(negedge clk);
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b0; sel[2] = 4'hF; adr[2] = 32'h0;
        k = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk($sformatf("s6_ack_c%0d", c), 32'(ack[2]), 32'(c % 2));
            chk($sformatf("s6_err_c%0d", c), 32'(err[2]), 32'd0);
            if (ack[2]) begin
                if (k < 3) chk($sformatf("s6_dat%0d", k), dat_r[2], mm[2][k]);
                k++;
                if (k < 3) adr[2] = 32'(k * 4);
                else begin cyc[2] = 1'b0; stb[2] = 1'b0; end
            end
        end
        chk("s6_ack_count", 32'(k), 32'd3);
        cyc[2] = 1'b0; stb[2] = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
